// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Multicycle main control FSM and ALU decoder for the cache-backed processor
// datapath. Each instruction is sequenced through fetch, decode, execute,
// memory and writeback steps. Instruction fetches and data accesses stall
// until the cache controller raises mem_ready.
//
// Optional feature macro: ILLEGAL_OP_TRAP_EN
//   defined   : illegal opcode/funct in DECODE sets sticky illegal_op and
//               parks the FSM in HALT (all controls 0) until rst.
//   undefined : illegal instructions return DECODE -> FETCH (2-cycle NOP);
//               illegal_op is tied to 0 and HALT does not exist.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset (state -> FETCH)
//   opcode, funct     : instr[31:26] and instr[5:0] from the IR
//   zero              : ALU zero flag, used only in BRANCH
//   mem_ready         : cache access completes this cycle
//   alu_ctrl          : 000 add, 001 sub, 010 and, 011 or, 101 slt
//   alu_src_a/_b      : ALU operand selects
//   iord              : memory address select (0 = PC, 1 = ALUOut)
//   mem_rd, mem_wr    : cache read / write requests
//   ir_write, pc_write: IR and PC load enables
//   pc_src            : PC source select
//   reg_write, reg_dst, mem_to_reg : register file write controls
//   illegal_op        : sticky illegal-instruction flag
// ---------------------------------------------------------------------------
module mc_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_ctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`ifdef ILLEGAL_OP_TRAP_EN
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
`else
    S_JUMP    = 4'd11
`endif
  } state_t;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

  // R-type funct decode: returns {legal, alu_ctrl}.
  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    logic [3:0] r;
    case (f)
      6'b100000: r = {1'b1, 3'b000};
      6'b100010: r = {1'b1, 3'b001};
      6'b100100: r = {1'b1, 3'b010};
      6'b100101: r = {1'b1, 3'b011};
      6'b101010: r = {1'b1, 3'b101};
      default:   r = {1'b0, 3'b000};
    endcase
    return r;
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] funct_dec_s;

  assign funct_dec_s = decode_funct(funct);

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control decode from the registered state.
  always_comb begin
    next_state_s = state_r;
    alu_ctrl     = 3'b000;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    iord         = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        // IR/PC load only on the cycle the fetch actually completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target (PC + imm<<2) is computed speculatively here.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE: begin
            if (funct_dec_s[3]) begin
              next_state_s = S_EXECUTE;
            end else begin
              next_state_s = ILLEGAL_NEXT;
            end
          end
          OP_BEQ:  next_state_s = S_BRANCH;
          OP_ADDI: next_state_s = S_ADDIEX;
          OP_J:    next_state_s = S_JUMP;
          default: next_state_s = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW) begin
          next_state_s = S_MEMRD;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_MEMRD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_EXECUTE: begin
        alu_src_a    = 1'b1;
        alu_ctrl     = funct_dec_s[2:0];
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write    = 1'b1;
        reg_dst      = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_ctrl     = 3'b001;
        pc_src       = 2'b01;
        pc_write     = zero;
        next_state_s = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write    = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        pc_src       = 2'b10;
        pc_write     = 1'b1;
        next_state_s = S_FETCH;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT: begin
        next_state_s = S_HALT;
      end
`endif
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_r;

  // Sticky trap flag, set on the DECODE -> HALT transition, cleared by rst only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else if (state_r == S_DECODE && next_state_s == S_HALT) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal_op = illegal_r;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
